// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the polynomial stream FSM encoding.
package kyber_pkg;

  localparam int KYBER_WIDTH = 12;
  localparam int KYBER_N     = 256;
  localparam int KYBER_Q     = 3329;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } stream_state_t;

endpackage

// File: rtl/coeff_sub_mod.sv
// Canonical modular difference (a - b) mod Q for operands in 0..2^WIDTH-1.
module coeff_sub_mod #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);

  localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH:0]   d;

  // Reduce both operands once, subtract, fold a negative result back by +Q.
  // The fold is done in WIDTH bits: ra - rb + Q is in 0..Q-1, so the
  // modulo-2^WIDTH wrap of the low bits yields the exact value.
  always_comb begin
    ra   = (a >= QW) ? a - QW : a;
    rb   = (b >= QW) ? b - QW : b;
    d    = {1'b0, ra} - {1'b0, rb};
    diff = d[WIDTH] ? d[WIDTH-1:0] + QW : d[WIDTH-1:0];
  end

endmodule

// File: rtl/poly_sub_stream.sv
// Streams one polynomial frame of N coefficient pairs through a modular
// subtractor with a one-deep registered output stage and ready/valid flow.
module poly_sub_stream
  import kyber_pkg::*;
#(
  parameter int WIDTH = KYBER_WIDTH,
  parameter int N     = KYBER_N,
  parameter int Q     = KYBER_Q
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  stream_state_t    state;
  stream_state_t    state_nxt;
  logic [IW-1:0]    idx;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] diff;

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign busy     = (state != ST_IDLE);

  coeff_sub_mod #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_sub (
    .a    (a_data),
    .b    (b_data),
    .diff (diff)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: start only honoured in IDLE; frame ends when the last beat leaves.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)                          state_nxt = ST_RUN;
      ST_RUN:   if (in_xfer && (idx == LAST_IDX))   state_nxt = ST_FLUSH;
      ST_FLUSH: if (out_xfer && out_last)           state_nxt = ST_IDLE;
      default:                                      state_nxt = ST_IDLE;
    endcase
  end

  // Coefficient index of the next accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         idx <= '0;
    else if ((state == ST_IDLE) && start) idx <= '0;
    else if (in_xfer)                   idx <= idx + IW'(1);
  end

  // Output stage: load on input transfer, drain on output transfer, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (in_xfer) begin
      out_data  <= diff;
      out_valid <= 1'b1;
      out_last  <= (idx == LAST_IDX);
    end else if (out_xfer) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Completion pulse, coincident with the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state == ST_FLUSH) && out_xfer && out_last;
  end

endmodule

// File: tb/tb_poly_sub_stream.sv
// Directed and random-frame bench for poly_sub_stream.
module tb_poly_sub_stream;

  localparam int WIDTH = 12;
  localparam int N     = 256;
  localparam int Q     = 3329;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy;
  logic             done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_data = '0;
  logic [WIDTH-1:0] b_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  int checks   = 0;
  int failures = 0;

  poly_sub_stream #(.WIDTH(WIDTH), .N(N), .Q(Q)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_data    (a_data),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic int ref_sub(input int a, input int b);
    return ((a % Q) - (b % Q) + Q) % Q;
  endfunction

  // Monitor: scoreboard of accepted pairs, beat ordering, stall stability.
  int               exp_q[$];
  int               beats = 0;
  int               done_cnt = 0;
  int               e_val;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] data_prev = '0;
  logic             last_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      beats      = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(data_prev));
        chk("stall_last", int'(out_last), int'(last_prev));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_val = exp_q.pop_front();
          chk("beat_data", int'(out_data), e_val);
        end
        chk("beat_last", int'(out_last), int'(beats == N - 1));
        chk("beat_busy", int'(busy), 1);
        beats++;
      end
      if (out_valid && !out_ready) chk("stall_in_ready", int'(in_ready), 0);
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      last_prev  = out_last;
      if (in_valid && in_ready) exp_q.push_back(ref_sub(int'(a_data), int'(b_data)));
      if (done) begin
        done_cnt++;
        chk("done_beats", beats, N);
        chk("done_busy", int'(busy), 0);
        chk("done_queue_empty", exp_q.size(), 0);
        beats = 0;
      end
    end
  end

  int sent = 0;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"},  int'(out_last), 0);
    chk({tag, "_out_data"},  int'(out_data), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_in_ready"},  int'(in_ready), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    sent     = 0;
    done_cnt = 0;
    chk("start_busy", int'(busy), 1);
  endtask

  // Feed random pairs until npairs accepted; optional stall, stray start, reset.
  task automatic feed(input int npairs, input int bp_beat, input int start_at, input int rst_at);
    int stall_left = 0;
    bit bp_done = 0;
    bit st_done = 0;
    int cyc = 0;
    while (sent < npairs && cyc < 3000) begin
      if (rst_at >= 0 && sent == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        start = 1'b0;
        return;
      end
      a_data   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      b_data   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      in_valid = 1'b1;
      start    = (start_at >= 0 && sent == start_at && !st_done);
      if (start) st_done = 1;
      if (bp_beat >= 0 && !bp_done && beats >= bp_beat) begin
        bp_done    = 1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("feed_complete", sent, npairs);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] want;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a: 12'd5,    b: 12'd10,   want: 12'd3324};
    vecs[1] = '{a: 12'd4095, b: 12'd0,    want: 12'd766};
    vecs[2] = '{a: 12'd0,    b: 12'd4095, want: 12'd2563};
    vecs[3] = '{a: 12'd3328, b: 12'd3328, want: 12'd0};
    vecs[4] = '{a: 12'd3329, b: 12'd0,    want: 12'd0};
    vecs[5] = '{a: 12'd0,    b: 12'd1,    want: 12'd3328};
    vecs[6] = '{a: 12'd100,  b: 12'd50,   want: 12'd50};
    vecs[7] = '{a: 12'd3328, b: 12'd0,    want: 12'd3328};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame A: directed vectors first, then random pairs with a 10-cycle stall.
    do_start();
    for (int i = 0; i < 8; i++) begin
      a_data    = vecs[i].a;
      b_data    = vecs[i].b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), int'(in_ready), 1);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].want));
    end
    feed(N, 100, -1, -1);
    wait_done("frameA");

    // Frame B: stray start around beat 100 must be ignored.
    do_start();
    feed(N, -1, 100, -1);
    wait_done("frameB");

    // Frame C: reset mid-frame, then no stray beats and a clean frame D.
    do_start();
    feed(N, -1, -1, 50);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a_data   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      @(posedge clk); #1;
      chk("post_reset_out_valid", int'(out_valid), 0);
      chk("post_reset_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    do_start();
    feed(N, -1, -1, -1);
    wait_done("frameD");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_sub_stream.md
POLY_SUB_STREAM -- requirements
Module: poly_sub_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 12, coefficient width in bits.
REQ-002 SHALL have parameter N, default 256, coefficients per polynomial.
REQ-003 SHALL have parameter Q, default 3329, modulus.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a frame of N coefficients.
REQ-007 SHALL have port busy  output  1  high from accepted start until the frame completes.
REQ-008 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-009 SHALL have port in_valid  input  1  a_data/b_data pair valid.
REQ-010 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-011 SHALL have port a_data  input  WIDTH  minuend coefficient, any value 0..2^WIDTH-1.
REQ-012 SHALL have port b_data  input  WIDTH  subtrahend coefficient, any value 0..2^WIDTH-1.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-015 SHALL have port out_data  output  WIDTH  (a_data - b_data) mod Q, canonical 0..Q-1.
REQ-016 SHALL have port out_last  output  1  high with coefficient index N-1.

Function
REQ-017 SHALL implement FSM IDLE, RUN, FLUSH: IDLE->RUN on start; RUN->FLUSH when pair N-1 is accepted; FLUSH->IDLE when beat N-1 is taken downstream.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL drive in_ready = (state==RUN) and (out_valid==0 or out_ready==1).
REQ-020 SHALL count input transfers (in_valid and in_ready) with a log2(N)-bit index cleared on start, wrapping never within a frame.
REQ-021 SHALL reduce each operand by one conditional subtraction of Q (operand >= Q -> operand - Q); one subtraction suffices because 2^WIDTH-1 < 2Q.
REQ-022 SHALL compute result = ra - rb if ra >= rb, else ra - rb + Q, with a WIDTH+1-bit intermediate, yielding 0..Q-1.
REQ-023 SHALL register result, out_valid and out_last one cycle after an input transfer (latency 1).
REQ-024 SHALL hold out_data, out_valid, out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid after an output transfer unless a new input transfer occurs in the same cycle, in which case the new result loads.
REQ-026 SHALL sustain one coefficient per cycle when in_valid and out_ready stay high.
REQ-027 SHALL pulse done in the cycle after beat N-1 is taken downstream, with busy falling in that same cycle.
REQ-028 SHALL drive busy high in RUN and FLUSH.

Reset
REQ-029 SHALL on rst_n low asynchronously force state IDLE, index 0, out_valid 0, out_last 0, out_data 0, done 0, busy 0, in_ready 0.
REQ-030 SHALL discard any frame in progress on reset; no partial output beat SHALL appear after release.
REQ-031 SHALL require a fresh start after reset release.

Structure
REQ-032 SHALL take Q, N, WIDTH defaults and FSM state encoding from shared package kyber_pkg.
REQ-033 SHALL place REQ-021/REQ-022 arithmetic in combinational sub-module coeff_sub_mod (inputs a, b; output canonical difference).

Verification
REQ-034 SHALL check a=5, b=10 -> out_data 3324 one cycle after transfer.
REQ-035 SHALL check a=4095, b=0 -> 766; a=0, b=4095 -> 2563; a=3328, b=3328 -> 0.
REQ-036 SHALL check full frame of N=256 random pairs against a reference model: 256 beats, out_last only on beat 255, single done pulse, busy falls with done.
REQ-037 SHALL check backpressure: out_ready low for 10 cycles mid-frame -> out_data stable, in_ready low, no beat lost or duplicated.
REQ-038 SHALL check start pulsed at beat 100 -> ignored, frame still ends after 256 beats.
REQ-039 SHALL check rst_n asserted at beat 50 -> outputs per REQ-029 immediately; new start yields a clean 256-beat frame.
